// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the round datapath.
package aes_pkg;

  // State and key layout: [row][col][7:0], FIPS byte n sits at row n%4, col n/4.
  typedef logic [3:0][3:0][7:0] state_t;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  // Round constants, entry i is used in round i.
  localparam logic [10:1][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  // Round constant for a round index; indices outside 1..10 never occur in ROUND.
  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    logic [7:0] val;
    val = 8'h00;
    if (idx >= 4'd1 && idx <= 4'd10) val = RCON[idx];
    return val;
  endfunction

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product by shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // S-box computed as inverse (a^254, which also maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule: current round key -> next round key.
module aes_key_step
  import aes_pkg::*;
(
  input  state_t      key,
  input  logic [7:0]  rcon,
  output state_t      next_key
);

  logic [3:0][7:0] temp;

  // RotWord+SubWord+Rcon on column 3, then a running XOR across columns 0..3.
  always_comb begin
    logic [7:0] acc;
    temp[0] = sbox(key[1][3]) ^ rcon;
    temp[1] = sbox(key[2][3]);
    temp[2] = sbox(key[3][3]);
    temp[3] = sbox(key[0][3]);
    next_key = '0;
    for (int r = 0; r < 4; r++) begin
      acc = temp[r];
      for (int c = 0; c < 4; c++) begin
        acc = acc ^ key[r][c];
        next_key[r][c] = acc;
      end
    end
  end

endmodule

// File: rtl/mix_columns.sv
// MixColumns: each column multiplied by the fixed {02,03,01,01} circulant.
module mix_columns
  import aes_pkg::*;
(
  input  state_t state,
  output state_t result
);

  // Multiplication by 3 is expressed as xtime(a)^a, so only xtime is needed.
  always_comb begin
    result = '0;
    for (int c = 0; c < 4; c++) begin
      result[0][c] = xtime(state[0][c]) ^ xtime(state[1][c]) ^ state[1][c]
                   ^ state[2][c] ^ state[3][c];
      result[1][c] = state[0][c] ^ xtime(state[1][c]) ^ xtime(state[2][c])
                   ^ state[2][c] ^ state[3][c];
      result[2][c] = state[0][c] ^ state[1][c] ^ xtime(state[2][c])
                   ^ xtime(state[3][c]) ^ state[3][c];
      result[3][c] = xtime(state[0][c]) ^ state[0][c] ^ state[1][c]
                   ^ state[2][c] ^ xtime(state[3][c]);
    end
  end

endmodule

// File: rtl/shift_rows.sv
// ShiftRows: row r rotated left by r byte positions.
module shift_rows
  import aes_pkg::*;
(
  input  state_t state,
  output state_t result
);

  // Pure rewiring; column index wraps modulo 4.
  always_comb begin
    result = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        result[r][c] = state[r][(c + r) % 4];
      end
    end
  end

endmodule

// File: rtl/sub_bytes.sv
// SubBytes: S-box applied to every byte of the state.
module sub_bytes
  import aes_pkg::*;
(
  input  state_t state,
  output state_t result
);

  // Byte-wise substitution, no mixing between bytes.
  always_comb begin
    result = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        result[r][c] = sbox(state[r][c]);
      end
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encrypt sequencer: one round per clock, key schedule on the fly.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int CNT_W = $clog2(NR + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  state_t           in_block,
  input  state_t           in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output state_t           out_block,
  output logic             busy,
  output logic [CNT_W-1:0] round_idx
);

  // The key schedule and round constant table only cover AES-128.
  if (NR != 10 || CNT_W != 4) begin : g_bad_nr
    $error("aes_round_ctrl supports only NR=10 with CNT_W=4");
  end

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NR);

  fsm_t       fsm;
  state_t     state_q;
  state_t     rkey;
  state_t     rkey_next;
  state_t     sb_out;
  state_t     sr_out;
  state_t     mc_out;
  state_t     round_out;
  logic [7:0] rcon_cur;
  logic       last_round;

  assign rcon_cur   = rcon_of(round_idx);
  assign last_round = (round_idx == LAST_ROUND);

  aes_key_step u_key_step (
    .key      (rkey),
    .rcon     (rcon_cur),
    .next_key (rkey_next)
  );

  sub_bytes u_sub_bytes (
    .state  (state_q),
    .result (sb_out)
  );

  shift_rows u_shift_rows (
    .state  (sb_out),
    .result (sr_out)
  );

  mix_columns u_mix_columns (
    .state  (sr_out),
    .result (mc_out)
  );

  // Final round skips MixColumns; every round ends with AddRoundKey.
  assign round_out = (last_round ? sr_out : mc_out) ^ rkey_next;

  // Sequencer: accept in IDLE, iterate rounds, hold ciphertext until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_block <= '0;
      busy      <= 1'b0;
      round_idx <= '0;
      state_q   <= '0;
      rkey      <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_q   <= in_block ^ in_key;
            rkey      <= in_key;
            round_idx <= CNT_W'(1);
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            fsm       <= ROUND;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ROUND: begin
          rkey <= rkey_next;
          if (last_round) begin
            out_block <= round_out;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            state_q   <= round_out;
            round_idx <= round_idx + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            round_idx <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

endmodule
